writeback_stage: RTL and testbench
==================================

# writeback_stage

Final (WB) stage of the 5-stage MIPS pipeline; drives the register-file write port. Holds the MEM/WB pipeline register, selects ALU result or load data, and sign/zero-extends sub-word loads. Each valid instruction issues exactly one register write, including under stall, with $0 writes suppressed. Also keeps a retired-instruction counter and, optionally, a forwarding port back to the EX stage.

## Interface
- DATA_W, 32, datapath width (only 32 supported)
- ADDR_W, 5, register index width
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold MEM/WB register contents
- flush  in  1  invalidate MEM/WB register at next edge
- mem_valid  in  1  MEM stage presents an instruction
- mem_alu_result  in  DATA_W  ALU result / effective address
- mem_load_data  in  DATA_W  word read from data memory
- mem_rd  in  ADDR_W  destination register
- mem_reg_write  in  1  instruction writes a register
- mem_mem_to_reg  in  1  1 = load data, 0 = ALU result
- mem_size  in  2  00 byte, 01 half, 10 word
- mem_unsigned  in  1  zero-extend sub-word load
- rf_din  out  DATA_W  register-file write data
- rf_waddr  out  ADDR_W  register-file write index
- rf_write  out  1  register-file write strobe
- wb_valid  out  1  MEM/WB register holds a valid instruction
- retire_count  out  32  instructions retired since reset

## Operation
- Capture: at a rising edge with stall=0 and flush=0, latch all mem_* fields and set wb_valid=mem_valid.
- Stall: with stall=1 and flush=0, all fields hold.
- Flush: flush=1 clears wb_valid regardless of stall. Flush wins over stall and capture.
- A one-bit committed flag is cleared on every capture and set at the first edge after a valid entry is present.
- rf_write = wb_valid & reg_write & (rd≠0) & ~committed. It is high for one cycle per instruction, and stall never repeats it.
- rf_waddr = latched rd. rf_din is computed combinationally from the latched fields:
  - mem_to_reg=0: alu_result.
  - Load, big-endian lanes, byte offset = alu_result[1:0]:
    - byte: offset 0 → bits 31:24, 1 → 23:16, 2 → 15:8, 3 → 7:0.
    - half: offset[1]=0 → bits 31:16, 1 → 15:0; offset[0] ignored.
    - word: full word.
  - Sign-extend unless unsigned=1. mem_size=11 is treated as word.
- retire_count increments by 1 on the edge that sets committed for a valid entry, whether or not that entry writes a register. Wraps 0xFFFFFFFF → 0.

## Timing
- Latency: fields presented before edge N appear on rf_* during cycle N→N+1. The register file samples the write within that cycle.
- Reset (asynchronous, immediate): wb_valid=0, committed=0, all latched fields=0, retire_count=0. Therefore rf_write=0, rf_din=0, rf_waddr=0.
- Reset mid-stall or mid-write: the pending write is discarded, not replayed.
- Flush in the same cycle rf_write is high: that write still completes (it is combinational in the current cycle). The entry is cleared at the edge.
- Back-to-back valid instructions with no stall: rf_write is high every cycle.

## Configuration
- WB_FWD_EN defined: adds outputs fwd_valid (1), fwd_rd (ADDR_W), fwd_data (DATA_W).
  - fwd_valid = wb_valid & reg_write & (rd≠0). It stays high for the full stall duration, independent of committed.
  - fwd_rd = latched rd; fwd_data = rf_din.
- WB_FWD_EN undefined: these ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset then ALU write: alu_result=0x0000_1234, rd=5, reg_write=1, mem_to_reg=0 → next cycle rf_write=1, rf_waddr=5, rf_din=0x0000_1234; retire_count=1 after the following edge.
- Signed byte load: load_data=0x80FF_7F01, alu_result[1:0]=0 → rf_din=0xFFFF_FF80. Same with unsigned=1 → 0x0000_0080. Offset 2, signed → 0x0000_007F.
- Half load: offset 2, signed, load_data=0x1234_8001 → rf_din=0xFFFF_8001.
- Stall: a valid write to rd=7 held by stall for 4 cycles → rf_write high for exactly 1 cycle; retire_count +1 only.
- Write to $0 and flush priority:
  - rd=0, reg_write=1 → rf_write stays 0; retire_count +1.
  - flush=1 and stall=1 together → wb_valid=0 next cycle, retire_count unchanged.
- Async reset asserted mid-cycle with a pending write → rf_write drops immediately, retire_count=0. With WB_FWD_EN, fwd_valid=0.

Source files
------------

// File: rtl/writeback_stage.sv
// ---------------------------------------------------------------------------
// writeback_stage
// Final (WB) stage of a 5-stage MIPS pipeline. Holds the MEM/WB pipeline
// register, selects ALU result or load data, aligns/extends sub-word loads
// (big-endian byte lanes) and drives the register-file write port. Each valid
// instruction produces exactly one register write, stall never repeats it,
// and writes to $0 are suppressed. A retired-instruction counter is kept.
//
// Optional feature: define WB_FWD_EN to add a forwarding port to EX.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   i_stall              hold MEM/WB contents
//   i_flush              invalidate MEM/WB at next edge (wins over stall)
//   i_mem_*              MEM-stage instruction fields
//   o_rf_din/waddr/write register-file write port
//   o_wb_valid           MEM/WB holds a valid instruction
//   o_retire_count       instructions retired since reset (wraps)
//   o_fwd_valid/rd/data  forwarding port (WB_FWD_EN only)
// ---------------------------------------------------------------------------
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_mem_valid,
  input  logic [DATA_W-1:0] i_mem_alu_result,
  input  logic [DATA_W-1:0] i_mem_load_data,
  input  logic [ADDR_W-1:0] i_mem_rd,
  input  logic              i_mem_reg_write,
  input  logic              i_mem_mem_to_reg,
  input  logic [1:0]        i_mem_size,
  input  logic              i_mem_unsigned,
  output logic [DATA_W-1:0] o_rf_din,
  output logic [ADDR_W-1:0] o_rf_waddr,
  output logic              o_rf_write,
  output logic              o_wb_valid,
  output logic [31:0]       o_retire_count
`ifdef WB_FWD_EN
  ,
  output logic              o_fwd_valid,
  output logic [ADDR_W-1:0] o_fwd_rd,
  output logic [DATA_W-1:0] o_fwd_data
`endif
);

  logic              r_valid;
  logic              r_committed;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_load;
  logic [ADDR_W-1:0] r_rd;
  logic              r_reg_write;
  logic              r_mem_to_reg;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [31:0]       r_retire;

  logic              w_capture;
  logic              w_commit;
  logic              w_wr_en;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_rf_din;

  assign w_capture = ~i_stall & ~i_flush;
  // An entry commits on the first edge it is present; later stall edges
  // see committed=1 and therefore neither rewrite nor recount it.
  assign w_commit  = r_valid & ~r_committed;
  assign w_wr_en   = r_valid & r_reg_write & (r_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_committed  <= 1'b0;
      r_alu        <= '0;
      r_load       <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_retire     <= 32'd0;
    end else begin
      // A flushed entry whose write is in flight still retires this edge.
      if (w_commit) r_retire <= r_retire + 32'd1;

      if (i_flush) begin
        r_valid     <= 1'b0;
        r_committed <= 1'b0;
      end else if (w_capture) begin
        r_valid      <= i_mem_valid;
        r_committed  <= 1'b0;
        r_alu        <= i_mem_alu_result;
        r_load       <= i_mem_load_data;
        r_rd         <= i_mem_rd;
        r_reg_write  <= i_mem_reg_write;
        r_mem_to_reg <= i_mem_mem_to_reg;
        r_size       <= i_mem_size;
        r_unsigned   <= i_mem_unsigned;
      end else if (r_valid) begin
        r_committed <= 1'b1;
      end
    end
  end

  // Big-endian lanes: offset 0 is the most significant byte.
  always_comb begin
    w_byte   = 8'h00;
    w_half   = 16'h0000;
    w_load   = r_load;
    w_rf_din = r_alu;
    case (r_alu[1:0])
      2'd0:    w_byte = r_load[31:24];
      2'd1:    w_byte = r_load[23:16];
      2'd2:    w_byte = r_load[15:8];
      default: w_byte = r_load[7:0];
    endcase
    w_half = r_alu[1] ? r_load[15:0] : r_load[31:16];
    case (r_size)
      2'b00:   w_load = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
      2'b01:   w_load = {{16{w_half[15] & ~r_unsigned}}, w_half};
      default: w_load = r_load;  // 10 and 11 both mean word
    endcase
    if (r_mem_to_reg) w_rf_din = w_load;
  end

  assign o_rf_din       = w_rf_din;
  assign o_rf_waddr     = r_rd;
  assign o_rf_write     = w_wr_en & ~r_committed;
  assign o_wb_valid     = r_valid;
  assign o_retire_count = r_retire;

`ifdef WB_FWD_EN
  // Forwarding stays live for the whole stall, unlike the one-shot write.
  assign o_fwd_valid = w_wr_en;
  assign o_fwd_rd    = r_rd;
  assign o_fwd_data  = w_rf_din;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, mem_valid;
  logic [31:0] mem_alu_result, mem_load_data;
  logic [4:0]  mem_rd;
  logic        mem_reg_write, mem_mem_to_reg, mem_unsigned;
  logic [1:0]  mem_size;
  logic [31:0] rf_din;
  logic [4:0]  rf_waddr;
  logic        rf_write, wb_valid;
  logic [31:0] retire_count;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  writeback_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_mem_valid      (mem_valid),
    .i_mem_alu_result (mem_alu_result),
    .i_mem_load_data  (mem_load_data),
    .i_mem_rd         (mem_rd),
    .i_mem_reg_write  (mem_reg_write),
    .i_mem_mem_to_reg (mem_mem_to_reg),
    .i_mem_size       (mem_size),
    .i_mem_unsigned   (mem_unsigned),
    .o_rf_din         (rf_din),
    .o_rf_waddr       (rf_waddr),
    .o_rf_write       (rf_write),
    .o_wb_valid       (wb_valid),
    .o_retire_count   (retire_count)
`ifdef WB_FWD_EN
    ,
    .o_fwd_valid      (fwd_valid),
    .o_fwd_rd         (fwd_rd),
    .o_fwd_data       (fwd_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] ld, input logic m2r, input logic [1:0] sz,
                       input logic uns);
    mem_valid      = v;
    mem_rd         = rd;
    mem_reg_write  = 1'b1;
    mem_alu_result = alu;
    mem_load_data  = ld;
    mem_mem_to_reg = m2r;
    mem_size       = sz;
    mem_unsigned   = uns;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 2'b10, 1'b0);
    mem_reg_write = 1'b0;
    #1;
    check("rst_rf_write", {31'b0, rf_write}, 32'd0);
    check("rst_rf_din",   rf_din, 32'h0);
    check("rst_rf_waddr", {27'b0, rf_waddr}, 32'd0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    check("rst_retire",   retire_count, 32'd0);
    step(); step();
    rst_n = 1'b1;

    // ALU write
    drive(1'b1, 5'd5, 32'h0000_1234, 32'h0, 1'b0, 2'b10, 1'b0);
    step();
    check("alu_write",  {31'b0, rf_write}, 32'd1);
    check("alu_waddr",  {27'b0, rf_waddr}, 32'd5);
    check("alu_din",    rf_din, 32'h0000_1234);
    check("alu_retire0", retire_count, 32'd0);
    mem_valid = 1'b0;
    step();
    check("alu_write_off", {31'b0, rf_write}, 32'd0);
    check("alu_retire1", retire_count, 32'd1);

    // Back-to-back loads
    drive(1'b1, 5'd3, 32'h0000_0100, 32'h80FF_7F01, 1'b1, 2'b00, 1'b0);
    step();
    check("lb_s_off0", rf_din, 32'hFFFF_FF80);
    check("lb_s_write", {31'b0, rf_write}, 32'd1);
    mem_unsigned = 1'b1;
    step();
    check("lbu_off0", rf_din, 32'h0000_0080);
    check("b2b_write", {31'b0, rf_write}, 32'd1);
    check("b2b_retire", retire_count, 32'd2);
    mem_unsigned = 1'b0; mem_alu_result = 32'h0000_0102;
    step();
    check("lb_s_off2", rf_din, 32'h0000_007F);
    mem_size = 2'b01; mem_load_data = 32'h1234_8001;
    step();
    check("lh_s_off2", rf_din, 32'hFFFF_8001);
    mem_size = 2'b10;
    step();
    check("lw", rf_din, 32'h1234_8001);
    mem_size = 2'b11; mem_alu_result = 32'h0000_0101;
    step();
    check("size11_word", rf_din, 32'h1234_8001);
    mem_size = 2'b00; mem_alu_result = 32'h0000_0103;
    step();
    check("lb_s_off3", rf_din, 32'h0000_0001);
    mem_size = 2'b01; mem_alu_result = 32'h0000_0101; mem_load_data = 32'hA5A5_0000;
    step();
    check("lh_s_off1", rf_din, 32'hFFFF_A5A5);
    mem_valid = 1'b0;
    step();
    check("loads_retire", retire_count, 32'd9);
    check("loads_idle_write", {31'b0, rf_write}, 32'd0);

    // Stall holds one write for 4 cycles
    drive(1'b1, 5'd7, 32'h0000_0077, 32'h0, 1'b0, 2'b10, 1'b0);
    step();
    check("stall_first_write", {31'b0, rf_write}, 32'd1);
    stall = 1'b1; mem_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_no_rewrite", {31'b0, rf_write}, 32'd0);
      check("stall_valid_hold", {31'b0, wb_valid}, 32'd1);
`ifdef WB_FWD_EN
      check("stall_fwd_valid", {31'b0, fwd_valid}, 32'd1);
      check("stall_fwd_data", fwd_data, 32'h0000_0077);
`endif
    end
    check("stall_retire", retire_count, 32'd10);
    stall = 1'b0;
    step();
    check("stall_release_valid", {31'b0, wb_valid}, 32'd0);

    // Write to $0 suppressed but retired
    drive(1'b1, 5'd0, 32'h0000_00AA, 32'h0, 1'b0, 2'b10, 1'b0);
    step();
    check("r0_no_write", {31'b0, rf_write}, 32'd0);
    check("r0_valid", {31'b0, wb_valid}, 32'd1);
    drive(1'b1, 5'd9, 32'h0000_0099, 32'h0, 1'b0, 2'b10, 1'b0);
    step();
    check("r9_write", {31'b0, rf_write}, 32'd1);
    check("r0_retired", retire_count, 32'd11);
    stall = 1'b1; mem_valid = 1'b0;
    step();
    check("r9_retire", retire_count, 32'd12);
    // Flush wins over stall and capture
    flush = 1'b1; mem_valid = 1'b1; mem_rd = 5'd4;
    step();
    check("flush_valid", {31'b0, wb_valid}, 32'd0);
    check("flush_no_write", {31'b0, rf_write}, 32'd0);
    check("flush_retire", retire_count, 32'd12);
    flush = 1'b0; stall = 1'b0; mem_valid = 1'b0;
    step();
    check("after_flush_valid", {31'b0, wb_valid}, 32'd0);

    // Flush while write is in flight: write completes this cycle
    drive(1'b1, 5'd6, 32'h0000_0066, 32'h0, 1'b0, 2'b10, 1'b0);
    step();
    flush = 1'b1; mem_valid = 1'b0;
    #1;
    check("flush_inflight_write", {31'b0, rf_write}, 32'd1);
    check("flush_inflight_waddr", {27'b0, rf_waddr}, 32'd6);
    step();
    check("flush_inflight_cleared", {31'b0, wb_valid}, 32'd0);
    check("flush_inflight_retire", retire_count, 32'd13);
    flush = 1'b0;

    // Async reset with pending write
    drive(1'b1, 5'd8, 32'h0000_0088, 32'h0, 1'b0, 2'b10, 1'b0);
    step();
    check("pre_reset_write", {31'b0, rf_write}, 32'd1);
    mem_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("areset_write", {31'b0, rf_write}, 32'd0);
    check("areset_retire", retire_count, 32'd0);
    check("areset_din", rf_din, 32'h0);
`ifdef WB_FWD_EN
    check("areset_fwd_valid", {31'b0, fwd_valid}, 32'd0);
`endif
    #3 rst_n = 1'b1;
    step();
    check("post_reset_write", {31'b0, rf_write}, 32'd0);
    check("post_reset_retire", retire_count, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
